alu_share_ctrl: RTL and testbench

Sequential front end that shares the single combinational 16-bit ALU between two requesters: the execute stage (requester 0) and the address/branch-compare unit (requester 1). Each cycle it grants at most one valid request by round-robin and drives the ALU's operands, opcode and flag input. It captures the ALU result in a one-entry response register and owns the architectural N/V/Z flag register that feeds back into the ALU's flag input.

---
 rtl/alu_share_ctrl_pkg.sv | 21 ++
 rtl/alu_share_ctrl_rr_arb2.sv | 28 ++
 rtl/alu_share_ctrl.sv | 86 ++++++++
 tb/tb_alu_share_ctrl.sv | 176 +++++++++++++++++
 4 files changed

// File: rtl/alu_share_ctrl_pkg.sv
// Shared ALU definitions: opcode encodings and flag bit positions.
// Used by the ALU, the decoder and the ALU sharing front end.
package alu_share_ctrl_pkg;

  typedef enum logic [2:0] {
    ALU_ADD = 3'b000,
    ALU_SUB = 3'b001,
    ALU_AND = 3'b010,
    ALU_OR  = 3'b011,
    ALU_XOR = 3'b100,
    ALU_SHL = 3'b101,
    ALU_SHR = 3'b110,
    ALU_PASS = 3'b111
  } alu_op_e;

  localparam int unsigned FLAG_N = 0;
  localparam int unsigned FLAG_V = 1;
  localparam int unsigned FLAG_Z = 2;
  localparam int unsigned FLAG_W = 3;

endpackage

// File: rtl/alu_share_ctrl_rr_arb2.sv
// Two-way round-robin arbiter; the priority pointer moves past the winner
// only when the grant is actually taken.
module rr_arb2 (
  input  logic       clk,
  input  logic       rst,
  input  logic [1:0] req,
  input  logic       advance,
  output logic [1:0] gnt
);

  logic prio;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      prio <= 1'b0;
    end else if (advance) begin
      prio <= ~gnt[1];
    end
  end

  always_comb begin
    gnt = req;
    if (&req) begin
      gnt = prio ? 2'b10 : 2'b01;
    end
  end

endmodule

// File: rtl/alu_share_ctrl.sv
// Shares one combinational ALU between the execute stage and the
// address/branch-compare unit; owns the response slot and the N/V/Z flags.
module alu_share_ctrl
  import alu_share_ctrl_pkg::*;
#(
  parameter int unsigned W    = 16,
  parameter int unsigned NREQ = 2
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [1:0]        req_valid,
  output logic [1:0]        req_ready,
  input  logic [2:0]        req_op0,
  input  logic [2:0]        req_op1,
  input  logic [W-1:0]      req_a0,
  input  logic [W-1:0]      req_a1,
  input  logic [W-1:0]      req_b0,
  input  logic [W-1:0]      req_b1,
  input  logic              req_upd0,
  input  logic              req_upd1,
  output logic [1:0]        rsp_valid,
  input  logic [1:0]        rsp_ready,
  output logic [W-1:0]      rsp_data,
  output logic [FLAG_W-1:0] rsp_flags,
  output logic [FLAG_W-1:0] flags,
  output logic [2:0]        alu_op,
  output logic [W-1:0]      alu_in1,
  output logic [W-1:0]      alu_in2,
  output logic [FLAG_W-1:0] alu_flag_in,
  input  logic [W-1:0]      alu_out,
  input  logic [FLAG_W-1:0] alu_flag
);

  logic [1:0]      gnt;
  logic [NREQ-1:0] drain_hit;
  logic            drain;
  logic            free;
  logic            acc;
  logic            sel;
  logic            upd_sel;

  // A ready bit without a matching valid bit is ignored by the mask.
  assign drain_hit = rsp_valid & rsp_ready;
  assign drain     = |drain_hit;
  assign free      = ~|rsp_valid | drain;
  assign req_ready = gnt & {2{free & ~rst}};
  assign acc       = |(req_valid & req_ready);

  rr_arb2 u_arb (
    .clk     (clk),
    .rst     (rst),
    .req     (req_valid),
    .advance (acc),
    .gnt     (gnt)
  );

  // With no grant sel stays 0, so requester 0 drives the (don't-care) ALU inputs.
  always_comb begin
    sel     = gnt[1];
    alu_op  = sel ? req_op1  : req_op0;
    alu_in1 = sel ? req_a1   : req_a0;
    alu_in2 = sel ? req_b1   : req_b0;
    upd_sel = sel ? req_upd1 : req_upd0;
  end

  assign alu_flag_in = flags;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rsp_valid <= '0;
      rsp_data  <= '0;
      rsp_flags <= '0;
      flags     <= '0;
    end else if (acc) begin
      rsp_valid <= gnt;
      rsp_data  <= alu_out;
      rsp_flags <= alu_flag;
      if (upd_sel) begin
        flags <= alu_flag;
      end
    end else if (drain) begin
      rsp_valid <= '0;
    end
  end

endmodule

// File: tb/tb_alu_share_ctrl.sv
// Directed bench for alu_share_ctrl with a behavioural ALU on the side.
module tb_alu_share_ctrl;
  import alu_share_ctrl_pkg::*;

  localparam int unsigned W = 16;

  logic         clk;
  logic         rst;
  logic [1:0]   req_valid;
  logic [1:0]   req_ready;
  logic [2:0]   req_op0, req_op1;
  logic [W-1:0] req_a0, req_a1, req_b0, req_b1;
  logic         req_upd0, req_upd1;
  logic [1:0]   rsp_valid;
  logic [1:0]   rsp_ready;
  logic [W-1:0] rsp_data;
  logic [2:0]   rsp_flags;
  logic [2:0]   flags;
  logic [2:0]   alu_op;
  logic [W-1:0] alu_in1, alu_in2;
  logic [2:0]   alu_flag_in;
  logic [W-1:0] alu_out;
  logic [2:0]   alu_flag;

  int unsigned total = 0;
  int unsigned bad   = 0;

  alu_share_ctrl #(.W(W), .NREQ(2)) dut (
    .clk(clk), .rst(rst),
    .req_valid(req_valid), .req_ready(req_ready),
    .req_op0(req_op0), .req_op1(req_op1),
    .req_a0(req_a0), .req_a1(req_a1),
    .req_b0(req_b0), .req_b1(req_b1),
    .req_upd0(req_upd0), .req_upd1(req_upd1),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
    .rsp_data(rsp_data), .rsp_flags(rsp_flags),
    .flags(flags),
    .alu_op(alu_op), .alu_in1(alu_in1), .alu_in2(alu_in2),
    .alu_flag_in(alu_flag_in),
    .alu_out(alu_out), .alu_flag(alu_flag)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Add/sub ALU standing in for the processor-level ALU.
  logic [W-1:0] b_eff;
  always_comb begin
    b_eff   = (alu_op == ALU_SUB) ? ~alu_in2 : alu_in2;
    alu_out = alu_in1 + b_eff + ((alu_op == ALU_SUB) ? 16'd1 : 16'd0);
    alu_flag = '0;
    alu_flag[FLAG_N] = alu_out[W-1];
    alu_flag[FLAG_Z] = (alu_out == '0);
    alu_flag[FLAG_V] = (alu_in1[W-1] == b_eff[W-1]) && (alu_out[W-1] != alu_in1[W-1]);
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst = 1'b1; req_valid = 2'b11; rsp_ready = 2'b00;
    req_op0 = '0; req_op1 = '0; req_a0 = '0; req_a1 = '0;
    req_b0 = '0; req_b1 = '0; req_upd0 = 1'b0; req_upd1 = 1'b0;
    #1;
    chk("rst_req_ready", 32'(req_ready), 32'h0);
    chk("rst_rsp_valid", 32'(rsp_valid), 32'h0);
    chk("rst_flags", 32'(flags), 32'h0);
    tick();
    rst = 1'b0; req_valid = 2'b00;

    // single add 0x7FFF + 1 with flag commit
    req_valid = 2'b01; req_op0 = 3'b000; req_a0 = 16'h7FFF; req_b0 = 16'h0001; req_upd0 = 1'b1;
    #1;
    chk("single_req_ready", 32'(req_ready), 32'h1);
    chk("single_alu_in1", 32'(alu_in1), 32'h7FFF);
    chk("single_alu_in2", 32'(alu_in2), 32'h0001);
    tick();
    chk("single_rsp_valid", 32'(rsp_valid), 32'h1);
    chk("single_rsp_data", 32'(rsp_data), 32'h8000);
    chk("single_rsp_flags", 32'(rsp_flags), 32'h3);
    chk("single_flags", 32'(flags), 32'h3);
    chk("single_alu_flag_in", 32'(alu_flag_in), 32'h3);
    req_valid = 2'b00;

    // asynchronous reset mid-cycle with a pending result and flags=011
    #2; rst = 1'b1; req_valid = 2'b01; #1;
    chk("midrst_rsp_valid", 32'(rsp_valid), 32'h0);
    chk("midrst_rsp_data", 32'(rsp_data), 32'h0);
    chk("midrst_rsp_flags", 32'(rsp_flags), 32'h0);
    chk("midrst_flags", 32'(flags), 32'h0);
    chk("midrst_alu_flag_in", 32'(alu_flag_in), 32'h0);
    chk("midrst_req_ready", 32'(req_ready), 32'h0);
    tick();
    chk("midrst_no_rsp", 32'(rsp_valid), 32'h0);
    rst = 1'b0; req_valid = 2'b00;

    // contention: strict alternation starting from requester 0
    req_a0 = 16'd1;  req_b0 = 16'd2;  req_upd0 = 1'b0;
    req_a1 = 16'd10; req_b1 = 16'd20; req_op1 = 3'b000; req_upd1 = 1'b0;
    req_valid = 2'b11; rsp_ready = 2'b11;
    for (int i = 0; i < 4; i++) begin
      #1;
      chk("cont_req_ready", 32'(req_ready), (i % 2 == 0) ? 32'h1 : 32'h2);
      tick();
      chk("cont_rsp_valid", 32'(rsp_valid), (i % 2 == 0) ? 32'h1 : 32'h2);
      chk("cont_rsp_data", 32'(rsp_data), (i % 2 == 0) ? 32'd3 : 32'd30);
    end

    // backpressure: requester 1 owns the slot and stalls; stray ready bit 0 ignored
    rsp_ready = 2'b01;
    for (int i = 0; i < 3; i++) begin
      #1;
      chk("bp_req_ready", 32'(req_ready), 32'h0);
      tick();
      chk("bp_rsp_valid", 32'(rsp_valid), 32'h2);
      chk("bp_rsp_data", 32'(rsp_data), 32'd30);
    end
    rsp_ready = 2'b10;
    #1;
    chk("bp_release_ready", 32'(req_ready), 32'h1);
    tick();
    chk("bp_release_rsp_valid", 32'(rsp_valid), 32'h1);
    chk("bp_release_rsp_data", 32'(rsp_data), 32'd3);

    // drain without a new accept
    req_valid = 2'b00; rsp_ready = 2'b01;
    tick();
    chk("drain_rsp_valid", 32'(rsp_valid), 32'h0);
    chk("drain_rsp_data_hold", 32'(rsp_data), 32'd3);
    rsp_ready = 2'b00;

    // flag commit control on requester 1
    req_valid = 2'b10; req_op1 = 3'b000; req_a1 = 16'h0001; req_b1 = 16'hFFFF; req_upd1 = 1'b0;
    #1;
    chk("fl_req_ready", 32'(req_ready), 32'h2);
    tick();
    chk("fl_noupd_rsp_valid", 32'(rsp_valid), 32'h2);
    chk("fl_noupd_rsp_data", 32'(rsp_data), 32'h0);
    chk("fl_noupd_rsp_flags", 32'(rsp_flags), 32'h4);
    chk("fl_noupd_flags", 32'(flags), 32'h0);
    req_upd1 = 1'b1; rsp_ready = 2'b10;
    tick();
    chk("fl_upd_rsp_valid", 32'(rsp_valid), 32'h2);
    chk("fl_upd_flags", 32'(flags), 32'h4);
    chk("fl_upd_alu_flag_in", 32'(alu_flag_in), 32'h4);

    // idle with a held result
    req_valid = 2'b00; rsp_ready = 2'b00; req_upd1 = 1'b0;
    for (int i = 0; i < 5; i++) begin
      tick();
      chk("idle_rsp_valid", 32'(rsp_valid), 32'h2);
      chk("idle_rsp_state", {13'd0, rsp_flags, rsp_data}, {13'd0, 3'b100, 16'h0000});
      chk("idle_flags", 32'(flags), 32'h4);
    end
    // prio must still favour requester 0 after requester 1's last win
    req_valid = 2'b11; rsp_ready = 2'b10;
    #1;
    chk("idle_prio", 32'(req_ready), 32'h1);
    tick();
    req_valid = 2'b00; rsp_ready = 2'b00;

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
